// File: rtl/music_seq_pkg.sv
// Shared types for the serial note sequencer: parser/player states, rest code, queued command.
package music_seq_pkg;

    localparam int unsigned CMD_TONE_MAX = 16;
    localparam int unsigned CMD_DUR_MAX  = 16;

    localparam logic [CMD_TONE_MAX-1:0] REST = '0;

    typedef enum logic {
        P_TONE,
        P_DUR
    } parse_state_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP
    } play_state_t;

    // Fields are sized for the widest supported tone/duration; narrower codes are zero-extended.
    typedef struct packed {
        logic [CMD_TONE_MAX-1:0] tone;
        logic [CMD_DUR_MAX-1:0]  dur;
    } cmd_t;

endpackage

// File: rtl/music_cmd_fifo.sv
// Synchronous command FIFO with registered read data and occupancy count.
module music_cmd_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/music_seq_player.sv
// Serial-fed note sequencer: {tone, dur} byte pairs are queued and played on a ms timebase.
module music_seq_player
    import music_seq_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 12000000,
    parameter int unsigned TONE_W     = 8,
    parameter int unsigned DUR_W      = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned GAP_MS     = 10,
    parameter int unsigned RESYNC_MS  = 50
) (
    input  logic                            sys_clk,
    input  logic                            sys_rst,
    input  logic                            rx_valid,
    input  logic [7:0]                      rx_data,
    input  logic                            play_en,
    input  logic                            flush,
    output logic [TONE_W-1:0]               tone_out,
    output logic                            tone_en,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow
);

    localparam int unsigned DIV      = CLK_FREQ / 1000;
    localparam int unsigned PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned RS_W     = (RESYNC_MS > 1) ? $clog2(RESYNC_MS) : 1;
    localparam int unsigned RS_LAST  = (RESYNC_MS > 0) ? RESYNC_MS - 1 : 0;
    localparam int unsigned GAP_CW   = (GAP_MS > 1) ? $clog2(GAP_MS) : 1;
    localparam int unsigned GAP_LAST = (GAP_MS > 0) ? GAP_MS - 1 : 0;

    logic [PRE_W-1:0]        pre_cnt;
    logic                    tick;

    parse_state_t            parse_state, parse_next;
    logic [TONE_W-1:0]       tone_cap;
    logic [DUR_W-1:0]        dur_in;
    logic [RS_W-1:0]         rs_cnt;
    logic                    push_req;
    cmd_t                    cmd_in;

    play_state_t             play_state, play_next;
    logic                    pop_req;
    logic [CMD_TONE_MAX-1:0] tone_q;
    logic [CMD_DUR_MAX-1:0]  dur_cnt;
    logic [GAP_CW-1:0]       gap_cnt;

    cmd_t                    fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;

    assign tick = (pre_cnt == PRE_W'(DIV - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst || tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign dur_in      = DUR_W'(rx_data);
    assign cmd_in.tone = CMD_TONE_MAX'(tone_cap);
    assign cmd_in.dur  = CMD_DUR_MAX'(dur_in);

    always_comb begin
        parse_next = parse_state;
        push_req   = 1'b0;
        if (flush) begin
            parse_next = P_TONE;
        end else begin
            case (parse_state)
                P_TONE: if (rx_valid) parse_next = P_DUR;
                P_DUR: begin
                    if (rx_valid) begin
                        parse_next = P_TONE;
                        push_req   = (dur_in != '0);
                    end else if (tick && rs_cnt == RS_W'(RS_LAST)) begin
                        parse_next = P_TONE;
                    end
                end
                default: parse_next = P_TONE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            parse_state <= P_TONE;
            tone_cap    <= '0;
            rs_cnt      <= '0;
        end else begin
            parse_state <= parse_next;
            if (!flush && rx_valid && parse_state == P_TONE) begin
                tone_cap <= TONE_W'(rx_data);
            end
            if (parse_state != P_DUR || rx_valid) begin
                rs_cnt <= '0;
            end else if (tick) begin
                rs_cnt <= rs_cnt + 1'b1;
            end
        end
    end

    music_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .clear (flush),
        .push  (push_req),
        .din   (cmd_in),
        .pop   (pop_req),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        play_next = play_state;
        pop_req   = 1'b0;
        if (flush) begin
            play_next = IDLE;
        end else begin
            case (play_state)
                IDLE: begin
                    if (play_en && !fifo_empty) begin
                        pop_req   = 1'b1;
                        play_next = LOAD;
                    end
                end
                LOAD: play_next = PLAY;
                PLAY: begin
                    if (tick && play_en && dur_cnt == CMD_DUR_MAX'(1)) begin
                        play_next = (GAP_MS == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (tick && play_en && gap_cnt == GAP_CW'(GAP_LAST)) begin
                        play_next = IDLE;
                    end
                end
                default: play_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            play_state <= IDLE;
            tone_q     <= '0;
            dur_cnt    <= '0;
            gap_cnt    <= '0;
        end else begin
            play_state <= play_next;
            if (play_state == LOAD && !flush) begin
                tone_q  <= fifo_dout.tone;
                dur_cnt <= fifo_dout.dur;
            end else if (play_state == PLAY && tick && play_en) begin
                dur_cnt <= dur_cnt - 1'b1;
            end
            if (play_state == PLAY) begin
                gap_cnt <= '0;
            end else if (play_state == GAP && tick && play_en) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst || flush) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop_req) begin
            overflow <= 1'b1;
        end
    end

    // tone_out keeps the last played code; tone_en alone gates sound.
    assign tone_out = tone_q[TONE_W-1:0];
    assign tone_en  = (play_state == PLAY) && play_en && !flush && (tone_q != REST);
    assign busy     = (play_state != IDLE);

endmodule
